// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM owner for the VGA core: prescaled display fetches
// take every active slot, a writer and a reader share the rest round-robin.
module vga_fb_arbiter #(
   parameter int FB_W       = 160,
   parameter int FB_H       = 120,
   parameter int ADDR_W     = 15,
   parameter int PRESC_LOG2 = 2,
   parameter int H_START    = 17,
   parameter int V_START    = 11,
   parameter int DISP_LEAD  = 2
) (
   input  logic              clk_25_175,
   input  logic              reset,
   input  logic [9:0]        hpos,
   input  logic [9:0]        vpos,
   output logic [11:0]       pixstream,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [11:0]       wr_data,
   output logic              wr_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [11:0]       rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [11:0]       mem_wdata,
   input  logic [11:0]       mem_rdata
);
   typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_WR, SLOT_RD} slot_t;

   localparam logic [10:0] FX_LO = 11'(H_START);
   localparam logic [10:0] FX_HI = 11'(H_START + (FB_W << PRESC_LOG2));
   localparam logic [9:0]  VY_LO = 10'(V_START);
   localparam logic [9:0]  VY_HI = 10'(V_START + (FB_H << PRESC_LOG2));

   logic [10:0]       fx;
   logic [10:0]       hrel;
   logic [9:0]        vrel;
   logic              win_open;
   logic [ADDR_W-1:0] disp_addr;
   logic              wr_elig;
   logic              rd_elig;
   logic              tie;
   slot_t             owner;
   slot_t             slot_reg;
   logic              ptr_rd_reg;

   // 11-bit fetch column so hpos near 799 runs off the line instead of wrapping
   assign fx       = {1'b0, hpos} + 11'(DISP_LEAD);
   assign win_open = (fx >= FX_LO) && (fx < FX_HI) && (vpos >= VY_LO) && (vpos < VY_HI);
   assign hrel     = fx - FX_LO;
   assign vrel     = vpos - VY_LO;
   assign disp_addr = ADDR_W'(32'(vrel >> PRESC_LOG2) * 32'(FB_W) + 32'(hrel >> PRESC_LOG2));

   // A requester only sees its grant one cycle after the decision, so a request
   // still high while its grant is showing is the one already served.
   assign wr_elig = wr_req && !wr_gnt;
   assign rd_elig = rd_req && !rd_gnt;
   assign tie     = !win_open && wr_elig && rd_elig;

   always_comb begin
      owner = SLOT_IDLE;
      if (win_open)
         owner = SLOT_DISP;
      else if (tie)
         owner = ptr_rd_reg ? SLOT_RD : SLOT_WR;
      else if (wr_elig)
         owner = SLOT_WR;
      else if (rd_elig)
         owner = SLOT_RD;
   end

   always_ff @(posedge clk_25_175 or posedge reset) begin
      if (reset) begin
         pixstream  <= 12'h000;
         wr_gnt     <= 1'b0;
         rd_gnt     <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= 12'h000;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= 12'h000;
         slot_reg   <= SLOT_IDLE;
         ptr_rd_reg <= 1'b0;
      end else begin
         wr_gnt   <= (owner == SLOT_WR);
         rd_gnt   <= (owner == SLOT_RD);
         mem_we   <= (owner == SLOT_WR);
         slot_reg <= owner;
         case (owner)
            SLOT_DISP: mem_addr <= disp_addr;
            SLOT_WR: begin
               mem_addr  <= wr_addr;
               mem_wdata <= wr_data;
            end
            SLOT_RD:   mem_addr <= rd_addr;
            default:   ;
         endcase
         if (tie)
            ptr_rd_reg <= ~ptr_rd_reg;
         // slot_reg tags the command whose RAM data is on mem_rdata this cycle
         pixstream <= (slot_reg == SLOT_DISP) ? mem_rdata : 12'h000;
         rd_valid  <= (slot_reg == SLOT_RD);
         if (slot_reg == SLOT_RD)
            rd_data <= mem_rdata;
      end
   end
endmodule
